// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: valid/ready word intake, internal frame build
// (start, LSB-first data, optional parity, 1-2 stop bits), fixed baud timing.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 frame_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_serializer: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state, state_next;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic                 tx_next;
    logic                 frame_done_next;
    logic                 bit_done;
    logic                 last_stop;
    logic                 accept;

    assign bit_done  = (state != IDLE) && (baud_cnt == BAUD_LAST);
    assign last_stop = (state == STOP) && bit_done && (bit_idx == STOP_LAST);
    assign tx_ready  = (state == IDLE) || last_stop;
    assign accept    = tx_valid && tx_ready;
    assign tx_busy   = (state != IDLE);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            tx         <= tx_next;
            frame_done <= frame_done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            if (state == IDLE || accept || bit_done) baud_cnt <= '0;
            else                                     baud_cnt <= baud_cnt + 1'b1;

            if (state_next != state) bit_idx <= '0;
            else if (bit_done)       bit_idx <= bit_idx + 1'b1;

            if (accept) begin
                shift_reg  <= tx_data;
                parity_bit <= (^tx_data) ^ 1'(PARITY_ODD);
            end else if (state == DATA && bit_done) begin
                shift_reg  <= shift_reg >> 1;
            end
        end
    end

    // NOTE: combinational blocks assign a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA:    if (bit_done && bit_idx == DATA_LAST)
                         state_next = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_done) state_next = STOP;
            STOP:    if (last_stop) state_next = accept ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tx is computed one cycle ahead so the registered line lines up with state.
    always_comb begin
        tx_next         = tx;
        frame_done_next = last_stop;
        if (accept || bit_done) begin
            unique case (state_next)
                START:   tx_next = 1'b0;
                DATA:    tx_next = (state == START) ? shift_reg[0] : shift_reg[1];
                PARITY:  tx_next = parity_bit;
                default: tx_next = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: four serializer configurations against a frame-level
// reference model built from start/data/parity/stop bit rules.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
    localparam int DB [4] = '{8, 8, 8, 7};
    localparam int PE [4] = '{0, 1, 1, 0};
    localparam int PO [4] = '{0, 0, 1, 0};
    localparam int SB [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] tx_data = '0;
    logic [3:0] tx_valid = '0;
    logic [3:0] tx_ready_w, tx_w, tx_busy_w, frame_done_w;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // 8N1
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready_w[0]), .tx(tx_w[0]), .tx_busy(tx_busy_w[0]), .frame_done(frame_done_w[0]));
    // 8E1
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready_w[1]), .tx(tx_w[1]), .tx_busy(tx_busy_w[1]), .frame_done(frame_done_w[1]));
    // 8O1
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready_w[2]), .tx(tx_w[2]), .tx_busy(tx_busy_w[2]), .frame_done(frame_done_w[2]));
    // 7N2
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[6:0]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready_w[3]), .tx(tx_w[3]), .tx_busy(tx_busy_w[3]), .frame_done(frame_done_w[3]));

    function automatic int frame_bits(input int d);
        return 1 + DB[d] + PE[d] + SB[d];
    endfunction

    function automatic logic [8:0] word_mask(input int d, input logic [8:0] w);
        logic [8:0] m;
        m = (9'h1 << DB[d]) - 9'h1;
        return w & m;
    endfunction

    // Frame bit k of word w: start, data LSB first, optional parity, stop bits.
    function automatic logic exp_bit(input int d, input logic [8:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= DB[d]) return w[k-1];
        if (PE[d] != 0 && k == DB[d] + 1) return (^w) ^ (PO[d] != 0);
        return 1'b1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain; 1: tx_data scrambled after accept; 2: also spurious tx_valid mid-frame.
    task automatic run_frame(input int d, input logic [8:0] word, input int mode);
        int len;
        logic [8:0] w;
        len = frame_bits(d) * CPB;
        w = word_mask(d, word);
        checks++;
        if (tx_ready_w[d] !== 1'b1) $display("FAIL ready_idle dut=%0d got %b want 1", d, tx_ready_w[d]);
        else passed++;
        tx_data = word;
        tx_valid[d] = 1'b1;
        tick();
        tx_valid[d] = 1'b0;
        for (int c = 0; c <= len; c++) begin
            logic e_tx, e_busy, e_done, e_ready;
            e_tx    = (c < len) ? exp_bit(d, w, c / CPB) : 1'b1;
            e_busy  = (c < len);
            e_done  = (c == len);
            e_ready = (c >= len - 1);
            checks += 4;
            if (tx_w[d] !== e_tx)
                $display("FAIL tx dut=%0d word=%h cyc=%0d got %b want %b", d, w, c, tx_w[d], e_tx);
            else passed++;
            if (tx_busy_w[d] !== e_busy)
                $display("FAIL tx_busy dut=%0d cyc=%0d got %b want %b", d, c, tx_busy_w[d], e_busy);
            else passed++;
            if (frame_done_w[d] !== e_done)
                $display("FAIL frame_done dut=%0d cyc=%0d got %b want %b", d, c, frame_done_w[d], e_done);
            else passed++;
            if (tx_ready_w[d] !== e_ready)
                $display("FAIL tx_ready dut=%0d cyc=%0d got %b want %b", d, c, tx_ready_w[d], e_ready);
            else passed++;
            if (mode >= 1) tx_data = 9'($urandom);
            if (mode == 2) tx_valid[d] = (c >= 3 && c < len - 6);
            tick();
        end
        tx_valid[d] = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks += 3;
        if (tx_w !== 4'hF) $display("FAIL reset_tx got %b want 1111", tx_w); else passed++;
        if (tx_busy_w !== 4'h0) $display("FAIL reset_busy got %b want 0000", tx_busy_w); else passed++;
        if (frame_done_w !== 4'h0) $display("FAIL reset_done got %b want 0000", frame_done_w); else passed++;
        rst_n = 1'b1;
        tick();
        checks++;
        if (tx_ready_w !== 4'hF) $display("FAIL reset_ready got %b want 1111", tx_ready_w); else passed++;
    endtask

    task automatic test_frame_formats;
        run_frame(0, 9'h0A5, 0);
        run_frame(1, 9'h007, 0);
        run_frame(2, 9'h007, 0);
        run_frame(3, 9'h055, 0);
    endtask

    task automatic test_random_frames;
        for (int i = 0; i < 12; i++)
            run_frame(i % 4, 9'($urandom), int'($urandom_range(0, 2)));
    endtask

    task automatic test_data_change;
        run_frame(0, 9'h05A, 1);
        run_frame(1, 9'h0E1, 2);
    endtask

    task automatic test_back_to_back;
        tx_data = 9'h03C;
        tx_valid[0] = 1'b1;
        tick();
        tx_data = 9'h0C3;
        for (int c = 0; c <= 80; c++) begin
            logic e_tx;
            e_tx = (c < 40) ? exp_bit(0, 9'h03C, c / CPB) :
                   (c < 80) ? exp_bit(0, 9'h0C3, (c - 40) / CPB) : 1'b1;
            checks += 4;
            if (tx_w[0] !== e_tx) $display("FAIL b2b_tx cyc=%0d got %b want %b", c, tx_w[0], e_tx);
            else passed++;
            if (tx_busy_w[0] !== (c < 80)) $display("FAIL b2b_busy cyc=%0d got %b want %b", c, tx_busy_w[0], c < 80);
            else passed++;
            if (frame_done_w[0] !== (c == 40 || c == 80))
                $display("FAIL b2b_done cyc=%0d got %b want %b", c, frame_done_w[0], c == 40 || c == 80);
            else passed++;
            if (tx_ready_w[0] !== (c == 39 || c >= 79))
                $display("FAIL b2b_ready cyc=%0d got %b want %b", c, tx_ready_w[0], c == 39 || c >= 79);
            else passed++;
            if (c == 40) tx_valid[0] = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid_frame;
        tx_data = 9'h0A5;
        tx_valid[0] = 1'b1;
        tick();
        tx_valid[0] = 1'b0;
        repeat (17) tick();
        checks++;
        if (tx_w[0] !== 1'b0) $display("FAIL pre_reset_tx got %b want 0", tx_w[0]); else passed++;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (tx_w[0] !== 1'b1) $display("FAIL abort_tx got %b want 1", tx_w[0]); else passed++;
        if (tx_busy_w[0] !== 1'b0) $display("FAIL abort_busy got %b want 0", tx_busy_w[0]); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (frame_done_w[0] !== 1'b0) $display("FAIL abort_done cyc=%0d got %b want 0", i, frame_done_w[0]);
            else passed++;
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (frame_done_w[0] !== 1'b0) $display("FAIL post_reset_done got %b want 0", frame_done_w[0]); else passed++;
        run_frame(0, 9'h081, 0);
    endtask

    initial begin
        test_reset();
        test_frame_formats();
        test_data_change();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Parametrised UART transmit serializer: accepts a data word over a valid/ready handshake, builds the frame internally (start, data LSB first, optional parity, 1 or 2 stop bits) and shifts it out on tx at a fixed clocks-per-bit rate. Replaces the fixed 10-bit frame/bit-select path in the UART TX datapath and owns its own bit counter and baud timing. Sits between the TX FIFO/host interface and the tx pad.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (≥2); 868 = 100 MHz / 115200
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY_EN, 0, 1 = insert parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits, legal 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_BITS  word to send, sampled only on accept
tx_valid  input  1  source has a word
tx_ready  output  1  block can accept a word this cycle
tx  output  1  serial line, idle high, registered
tx_busy  output  1  frame in progress (any state but IDLE)
frame_done  output  1  one-cycle pulse at end of last stop bit

Behaviour:
- Reset (async assert): tx=1, tx_busy=0, frame_done=0, state=IDLE, counters=0; tx_ready=1 after release.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE or START.
- Accept: tx_valid && tx_ready at a rising edge. tx_data latched into shift register; parity computed from latched word (XOR of bits, inverted if PARITY_ODD).
- tx is registered: first start-bit cycle (tx=0) is the cycle after accept.
- Each bit holds tx for exactly CLKS_PER_BIT cycles; baud counter 0..CLKS_PER_BIT-1, reset on each bit boundary and on accept.
- DATA: bit index 0..DATA_BITS-1, LSB first; shift register shifts right at each bit boundary.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- tx_ready (combinational) = IDLE, or last cycle of last stop bit. Back-to-back accept in that cycle goes directly to START: no idle gap between frames.
- frame_done pulses high for one cycle, registered, in the cycle after the last stop-bit cycle (coincides with the first cycle of IDLE or of the next START).
- tx_busy=1 from the cycle after accept until frame_done; stays 1 through a back-to-back frame.
- tx_valid while busy and not ready: ignored, no data captured; source must hold valid.
- tx_data changes after accept: no effect on the frame in flight.
- Reset mid-frame: frame aborted immediately, tx forced to 1, no frame_done.
- Illegal parameters (DATA_BITS outside 5..9, STOP_BITS outside 1..2, CLKS_PER_BIT<2): elaboration-time error.

Test Plan:
- CLKS_PER_BIT=4, DATA_BITS=8, no parity, 1 stop; send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles, 40 cycles total; frame_done one pulse; tx_ready low for 39 cycles.
- PARITY_EN=1 even, send 0x07 -> parity bit 1; PARITY_ODD=1 same data -> parity 0; frame 44 cycles.
- STOP_BITS=2, DATA_BITS=7, send 0x55 -> 0,1,0,1,0,1,0,1,1,1; stop held 8 cycles; 40 cycles total.
- tx_valid held high with 0x3C then 0xC3 -> second accepted in last stop cycle; start bit of frame 2 immediately follows stop of frame 1; tx_busy never drops; two frame_done pulses 40 cycles apart.
- Assert rst_n=0 during DATA bit 3 -> tx=1 same cycle; tx_busy=0; no frame_done; after release a new 0x81 transmits correctly.
- tx_data toggled every cycle during a frame, valid low -> transmitted bits match word latched at accept.
